// File: rtl/multicycle_control.sv
// Multicycle sequencer for the 16-bit core: FETCH/DECODE/EXEC/MEM/WB/HALT with a ready handshake on data memory.
// Optional macro ILLEGAL_OP_TRAP_EN: illegal opcodes trap to HALT instead of retiring as a NOP.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_in,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [15:0] ir,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_dst,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  alu_op,
  output logic [2:0]  state,
  output logic        halted,
  output logic        trap,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [2:0] OP_R    = 3'd0;
  localparam logic [2:0] OP_LW   = 3'd1;
  localparam logic [2:0] OP_SW   = 3'd2;
  localparam logic [2:0] OP_BEQ  = 3'd3;
  localparam logic [2:0] OP_J    = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  // Handshake: mem_read/mem_write stay high every MEM cycle until mem_ready is
  // seen high in that same cycle; mem_ready outside MEM has no effect.

  state_t      cur;
  logic [15:0] ir_q;
  logic [15:0] retired_q;
  logic        trap_q;
  logic [7:0]  wait_cnt;
  logic [2:0]  opcode;
  logic        timeout_hit;

  logic        pc_write_raw;
  logic [1:0]  pc_src_raw;
  logic        reg_dst_raw;
  logic        alu_src_raw;
  logic        mem_to_reg_raw;
  logic        reg_write_raw;
  logic        mem_read_raw;
  logic        mem_write_raw;
  logic [1:0]  alu_op_raw;

  assign opcode      = ir_q[15:13];
  assign timeout_hit = (MEM_TIMEOUT != 0) && (cur == S_MEM) && !mem_ready && (wait_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= S_FETCH;
      ir_q      <= '0;
      retired_q <= '0;
      trap_q    <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      // pc_write fires exactly once per instruction, so it doubles as the retire event.
      if (pc_write_raw) retired_q <= retired_q + 16'd1;
      wait_cnt <= '0;
      case (cur)
        S_FETCH: begin
          ir_q <= instr_in;
          cur  <= S_DECODE;
        end
        S_DECODE: begin
          case (opcode)
            OP_R, OP_LW, OP_SW, OP_BEQ: cur <= S_EXEC;
            OP_J:                       cur <= S_FETCH;
            OP_HALT:                    cur <= S_HALT;
            default: begin
`ifdef ILLEGAL_OP_TRAP_EN
              trap_q <= 1'b1;
              cur    <= S_HALT;
`else
              cur    <= S_FETCH;
`endif
            end
          endcase
        end
        S_EXEC: begin
          if (opcode == OP_BEQ)   cur <= S_FETCH;
          else if (opcode == OP_R) cur <= S_WB;
          else                     cur <= S_MEM;
        end
        S_MEM: begin
          if (mem_ready) begin
            cur <= (opcode == OP_LW) ? S_WB : S_FETCH;
          end else if (timeout_hit) begin
            trap_q <= 1'b1;
            cur    <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_WB:    cur <= S_FETCH;
        S_HALT:  cur <= S_HALT;
        default: cur <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write_raw   = 1'b0;
    pc_src_raw     = 2'b00;
    reg_dst_raw    = 1'b0;
    alu_src_raw    = 1'b0;
    mem_to_reg_raw = 1'b0;
    reg_write_raw  = 1'b0;
    mem_read_raw   = 1'b0;
    mem_write_raw  = 1'b0;
    alu_op_raw     = 2'b00;
    case (cur)
      S_DECODE: begin
        if (opcode == OP_J) begin
          pc_write_raw = 1'b1;
          pc_src_raw   = 2'b10;
        end
`ifndef ILLEGAL_OP_TRAP_EN
        else if (opcode == 3'd5 || opcode == 3'd6) begin
          pc_write_raw = 1'b1;
        end
`endif
      end
      S_EXEC: begin
        case (opcode)
          OP_R:         alu_op_raw  = 2'b10;
          OP_LW, OP_SW: alu_src_raw = 1'b1;
          OP_BEQ: begin
            alu_op_raw   = 2'b01;
            pc_write_raw = 1'b1;
            pc_src_raw   = {1'b0, zero};
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_read_raw  = (opcode == OP_LW);
        mem_write_raw = (opcode == OP_SW);
        pc_write_raw  = mem_ready && (opcode == OP_SW);
      end
      S_WB: begin
        reg_write_raw  = 1'b1;
        reg_dst_raw    = (opcode == OP_R);
        mem_to_reg_raw = (opcode == OP_LW);
        pc_write_raw   = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset masks every control line in the same cycle, so an in-flight write is dropped.
  assign pc_write   = pc_write_raw & ~rst;
  assign pc_src     = rst ? 2'b00 : pc_src_raw;
  assign reg_dst    = reg_dst_raw & ~rst;
  assign alu_src    = alu_src_raw & ~rst;
  assign mem_to_reg = mem_to_reg_raw & ~rst;
  assign reg_write  = reg_write_raw & ~rst;
  assign mem_read   = mem_read_raw & ~rst;
  assign mem_write  = mem_write_raw & ~rst;
  assign alu_op     = rst ? 2'b00 : alu_op_raw;

  assign ir      = ir_q;
  assign state   = cur;
  assign halted  = (cur == S_HALT);
  assign trap    = trap_q;
  assign retired = retired_q;

endmodule
